// File: rtl/cfg_pkg.sv
// Shared definitions for the configuration scan-chain loader: state encoding
// and a constant-evaluable ceil(log2) helper used to size counters.
package cfg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_WORD = 2'd1,
    ST_SHIFT     = 2'd2,
    ST_DONE      = 2'd3
  } state_e;

  // ceil(log2(n)); clog2(CHAIN_LEN+1) gives a counter width with 2**w > CHAIN_LEN
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((32'sd1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/scan_word_deser.sv
// Readback capture: packs bits arriving from the chain tail into words, first
// captured bit in bit 0, and pulses rd_valid_o per full word or final flush.
module scan_word_deser
  import cfg_pkg::*;
#(
  parameter int WORD_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear_i,
  input  logic                  shift_i,
  input  logic                  flush_i,
  input  logic                  scan_out_i,
  output logic [WORD_WIDTH-1:0] rd_data_o,
  output logic                  rd_valid_o
);

  localparam int IDX_W = (WORD_WIDTH > 1) ? clog2(WORD_WIDTH) : 1;

  logic [WORD_WIDTH-1:0] rx_q, rx_d;
  logic [WORD_WIDTH-1:0] rd_data_q, rd_data_d;
  logic [WORD_WIDTH-1:0] merged;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  rd_valid_q, rd_valid_d;

  always_comb begin
    rx_d          = rx_q;
    idx_d         = idx_q;
    rd_data_d     = rd_data_q;
    rd_valid_d    = 1'b0;
    merged        = rx_q;
    merged[idx_q] = scan_out_i;
    if (clear_i) begin
      rx_d  = '0;
      idx_d = '0;
    end else if (shift_i) begin
      // A flush emits whatever has been gathered; unused MSBs are still zero
      if (flush_i || (idx_q == IDX_W'(WORD_WIDTH - 1))) begin
        rd_data_d  = merged;
        rd_valid_d = 1'b1;
        rx_d       = '0;
        idx_d      = '0;
      end else begin
        rx_d  = merged;
        idx_d = idx_q + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_q       <= '0;
      idx_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rx_q       <= rx_d;
      idx_q      <= idx_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;

endmodule

// File: rtl/scan_cfg_loader.sv
// Writer end of the configuration scan chain: serializes CHAIN_LEN bits of a
// word stream into scan_in/scan_en and returns the displaced chain contents.
//
// Stream handshake: a word transfers on a rising edge where in_valid and
// in_ready are both high; in_ready never depends on in_valid, and in_data
// must stay stable while in_valid is high and in_ready is low.
module scan_cfg_loader
  import cfg_pkg::*;
#(
  parameter int WORD_WIDTH = 8,
  parameter int CHAIN_LEN  = 29,
  parameter int CNT_WIDTH  = clog2(CHAIN_LEN + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [WORD_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  scan_in,
  output logic                  scan_en,
  input  logic                  scan_out,
  output logic [WORD_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            dbg_state_o
);

  localparam int IDX_W = (WORD_WIDTH > 1) ? clog2(WORD_WIDTH) : 1;

  state_e                state_q, state_d;
  logic [WORD_WIDTH-1:0] tx_q, tx_d;
  logic [IDX_W-1:0]      bit_idx_q, bit_idx_d;
  logic [CNT_WIDTH-1:0]  chain_cnt_q, chain_cnt_d;
  logic                  scan_en_q, scan_in_q;
  logic                  in_ready_c, shift_c, flush_c, clear_c;
  logic                  last_word_bit, last_chain_bit;

  assign last_word_bit  = (bit_idx_q == IDX_W'(WORD_WIDTH - 1));
  assign last_chain_bit = (chain_cnt_q == CNT_WIDTH'(CHAIN_LEN - 1));

  always_comb begin
    state_d     = state_q;
    tx_d        = tx_q;
    bit_idx_d   = bit_idx_q;
    chain_cnt_d = chain_cnt_q;
    in_ready_c  = 1'b0;
    shift_c     = 1'b0;
    flush_c     = 1'b0;
    clear_c     = 1'b0;
    if (abort) begin
      state_d     = ST_IDLE;
      tx_d        = '0;
      bit_idx_d   = '0;
      chain_cnt_d = '0;
      clear_c     = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d     = ST_WAIT_WORD;
            bit_idx_d   = '0;
            chain_cnt_d = '0;
            clear_c     = 1'b1;
          end
        end
        ST_WAIT_WORD: begin
          in_ready_c = 1'b1;
          if (in_valid) begin
            tx_d      = in_data;
            bit_idx_d = '0;
            state_d   = ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          shift_c     = 1'b1;
          tx_d        = tx_q >> 1;
          bit_idx_d   = bit_idx_q + IDX_W'(1);
          chain_cnt_d = chain_cnt_q + CNT_WIDTH'(1);
          if (last_chain_bit) begin
            // Remaining bits of the current word are dropped here
            flush_c     = 1'b1;
            state_d     = ST_DONE;
            tx_d        = '0;
            bit_idx_d   = '0;
            chain_cnt_d = '0;
          end else if (last_word_bit) begin
            in_ready_c = 1'b1;
            if (in_valid) begin
              tx_d      = in_data;
              bit_idx_d = '0;
            end else begin
              state_d = ST_WAIT_WORD;
            end
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // scan_en/scan_in are registered from the next state so they line up with SHIFT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      tx_q        <= '0;
      bit_idx_q   <= '0;
      chain_cnt_q <= '0;
      scan_en_q   <= 1'b0;
      scan_in_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      tx_q        <= tx_d;
      bit_idx_q   <= bit_idx_d;
      chain_cnt_q <= chain_cnt_d;
      scan_en_q   <= (state_d == ST_SHIFT);
      scan_in_q   <= (state_d == ST_SHIFT) ? tx_d[0] : 1'b0;
    end
  end

  scan_word_deser #(
    .WORD_WIDTH(WORD_WIDTH)
  ) u_deser (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (clear_c),
    .shift_i   (shift_c),
    .flush_i   (flush_c),
    .scan_out_i(scan_out),
    .rd_data_o (rd_data),
    .rd_valid_o(rd_valid)
  );

  assign in_ready    = in_ready_c;
  assign scan_en     = scan_en_q;
  assign scan_in     = scan_in_q;
  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_DONE);
  assign dbg_state_o = state_q;

endmodule
